// File: rtl/tick_gen_pkg.sv
// Shared constants and per-channel state types for the tick_gen_multi tick generator.
package tick_gen_pkg;

  localparam int TG_CNT_W       = 22;
  localparam int TG_DEFAULT_DIV = 4000000;
  // Internal channel state width; the CNT_W parameter must not exceed it.
  localparam int TG_STATE_W     = 32;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } tg_mode_e;

  typedef struct packed {
    logic [TG_STATE_W-1:0] cnt;
    logic [TG_STATE_W-1:0] p_act;
    logic [TG_STATE_W-1:0] p_sh;
    logic                  sh_valid;
    tg_mode_e              mode;
    logic                  done;
  } tg_ch_state_t;

endpackage

// File: rtl/tick_gen_ch.sv
// One tick channel: programmable period, periodic/one-shot mode, shadowed period updates.
// Optional square-wave output when TICK_GEN_SQUARE_EN is defined.
module tick_gen_ch
  import tick_gen_pkg::*;
#(
  parameter int CNT_W       = TG_CNT_W,
  parameter int DEFAULT_DIV = TG_DEFAULT_DIV
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_in,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_period,
  input  logic             wr_oneshot,
  output logic             tick,
  output logic             done
`ifdef TICK_GEN_SQUARE_EN
  ,
  output logic             sq
`endif
);

  localparam logic [TG_STATE_W-1:0] RST_P = TG_STATE_W'(DEFAULT_DIV);

  tg_ch_state_t          r_st;
  tg_ch_state_t          w_st_nxt;
  logic                  r_tick;
  logic                  w_tick_nxt;
  logic                  w_wrap;
  logic [TG_STATE_W-1:0] w_period;

  assign w_period = TG_STATE_W'(wr_period);
  assign w_wrap   = (r_st.cnt == (r_st.p_act - TG_STATE_W'(1)));

  // Next-state: accepted write beats sync, sync beats hold/count.
  always_comb begin
    w_st_nxt   = r_st;
    w_tick_nxt = 1'b0;
    if (wr) begin
      w_st_nxt.cnt  = '0;
      w_st_nxt.done = 1'b0;
      w_st_nxt.p_sh = w_period;
      w_st_nxt.mode = wr_oneshot ? MODE_ONESHOT : MODE_PERIODIC;
      if (en && !r_st.done) begin
        w_st_nxt.sh_valid = 1'b1;
      end else begin
        w_st_nxt.p_act    = w_period;
        w_st_nxt.sh_valid = 1'b0;
      end
    end else if (sync_in) begin
      w_st_nxt.cnt  = '0;
      w_st_nxt.done = 1'b0;
      if (r_st.sh_valid) begin
        w_st_nxt.p_act    = r_st.p_sh;
        w_st_nxt.sh_valid = 1'b0;
      end else begin
        w_st_nxt.p_act = r_st.p_act;
      end
    end else if (!en || r_st.done) begin
      // Applying a shadow while stopped restarts the count so cnt stays below P_act.
      if (r_st.sh_valid) begin
        w_st_nxt.p_act    = r_st.p_sh;
        w_st_nxt.sh_valid = 1'b0;
        w_st_nxt.cnt      = '0;
      end else begin
        w_st_nxt.cnt = r_st.cnt;
      end
    end else if (w_wrap) begin
      w_st_nxt.cnt = '0;
      w_tick_nxt   = 1'b1;
      if (r_st.sh_valid) begin
        w_st_nxt.p_act    = r_st.p_sh;
        w_st_nxt.sh_valid = 1'b0;
      end else begin
        w_st_nxt.p_act = r_st.p_act;
      end
      if (r_st.mode == MODE_ONESHOT) begin
        w_st_nxt.done = 1'b1;
      end else begin
        w_st_nxt.done = 1'b0;
      end
    end else begin
      w_st_nxt.cnt = r_st.cnt + TG_STATE_W'(1);
    end
  end

  // Channel state and tick registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= '{cnt: '0, p_act: RST_P, p_sh: RST_P, sh_valid: 1'b0,
                  mode: MODE_PERIODIC, done: 1'b0};
      r_tick <= 1'b0;
    end else begin
      r_st   <= w_st_nxt;
      r_tick <= w_tick_nxt;
    end
  end

  assign tick = r_tick;
  assign done = r_st.done;

`ifdef TICK_GEN_SQUARE_EN
  logic r_sq;
  logic w_sq_nxt;

  // Square output toggles per tick and restarts low on sync or accepted write.
  always_comb begin
    w_sq_nxt = r_sq;
    if (wr || sync_in) begin
      w_sq_nxt = 1'b0;
    end else if (w_tick_nxt) begin
      w_sq_nxt = ~r_sq;
    end else begin
      w_sq_nxt = r_sq;
    end
  end

  // Square output register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sq <= 1'b0;
    end else begin
      r_sq <= w_sq_nxt;
    end
  end

  assign sq = r_sq;
`endif

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel tick generator top: decodes config writes, flags rejected writes, fans out sync.
// Optional square outputs (port sq) are built when TICK_GEN_SQUARE_EN is defined.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = TG_CNT_W,
  parameter int DEFAULT_DIV = TG_DEFAULT_DIV
) (
  input  logic                                              clk_in,
  input  logic                                              rst_n,
  input  logic [NUM_CH-1:0]                                 en,
  input  logic                                              sync_in,
  input  logic                                              cfg_valid,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]    cfg_ch,
  input  logic [CNT_W-1:0]                                  cfg_period,
  input  logic                                              cfg_oneshot,
  output logic                                              cfg_err,
  output logic [NUM_CH-1:0]                                 tick,
  output logic [NUM_CH-1:0]                                 done
`ifdef TICK_GEN_SQUARE_EN
  ,
  output logic [NUM_CH-1:0]                                 sq
`endif
);

  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CH_CMP_W = CH_W + 1;

  logic              w_cfg_ok;
  logic [NUM_CH-1:0] w_wr;
  logic              r_cfg_err;

  // Channel index is widened so a non-power-of-two NUM_CH can reject the spare codes.
  assign w_cfg_ok = cfg_valid && (cfg_period != CNT_W'(0)) &&
                    ({1'b0, cfg_ch} < CH_CMP_W'(NUM_CH));

  // Rejected-write flag, one cycle after the offending write.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_valid && !w_cfg_ok;
    end
  end

  assign cfg_err = r_cfg_err;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_wr[i] = w_cfg_ok && (cfg_ch == CH_W'(i));

    tick_gen_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .en         (en[i]),
      .sync_in    (sync_in),
      .wr         (w_wr[i]),
      .wr_period  (cfg_period),
      .wr_oneshot (cfg_oneshot),
      .tick       (tick[i]),
      .done       (done[i])
`ifdef TICK_GEN_SQUARE_EN
      ,
      .sq         (sq[i])
`endif
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi: directed corner sequences, a cfg_err vector table,
// and randomized traffic compared every cycle against a behavioural channel model.
module tb_tick_gen_multi;

  localparam int NCH = 3;
  localparam int DIV = 10;

  logic           clk_in = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] en;
  logic           sync_in;
  logic           cfg_valid;
  logic [1:0]     cfg_ch;
  logic [7:0]     cfg_period;
  logic           cfg_oneshot;
  logic           cfg_err;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] done;
`ifdef TICK_GEN_SQUARE_EN
  logic [NCH-1:0] sq;
`endif

  tick_gen_multi #(.NUM_CH(NCH), .CNT_W(8), .DEFAULT_DIV(DIV)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .en          (en),
    .sync_in     (sync_in),
    .cfg_valid   (cfg_valid),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_oneshot (cfg_oneshot),
    .cfg_err     (cfg_err),
    .tick        (tick),
    .done        (done)
`ifdef TICK_GEN_SQUARE_EN
    ,
    .sq          (sq)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: each channel counts enabled cycles since its last restart.
  int m_per [NCH];
  int m_pend[NCH];
  int m_age [NCH];
  bit m_os  [NCH];
  bit m_dn  [NCH];
  bit m_tk  [NCH];
  bit m_sq  [NCH];
  bit m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_per[c] = DIV; m_pend[c] = 0; m_age[c] = 0;
      m_os[c] = 1'b0; m_dn[c] = 1'b0; m_tk[c] = 1'b0; m_sq[c] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    bit acc;
    acc   = cfg_valid && (cfg_period != 8'd0) && (cfg_ch < NCH);
    m_err = cfg_valid && !acc;
    for (int c = 0; c < NCH; c++) begin
      m_tk[c] = 1'b0;
      if (acc && (cfg_ch == c)) begin
        m_age[c] = 0; m_os[c] = cfg_oneshot; m_sq[c] = 1'b0;
        if (en[c] && !m_dn[c]) m_pend[c] = cfg_period;
        else begin m_per[c] = cfg_period; m_pend[c] = 0; end
        m_dn[c] = 1'b0;
      end else if (sync_in) begin
        m_age[c] = 0; m_dn[c] = 1'b0; m_sq[c] = 1'b0;
        if (m_pend[c] != 0) begin m_per[c] = m_pend[c]; m_pend[c] = 0; end
      end else if (!en[c] || m_dn[c]) begin
        if (m_pend[c] != 0) begin m_per[c] = m_pend[c]; m_pend[c] = 0; m_age[c] = 0; end
      end else begin
        m_age[c]++;
        if (m_age[c] == m_per[c]) begin
          m_tk[c] = 1'b1; m_age[c] = 0; m_sq[c] = !m_sq[c];
          if (m_pend[c] != 0) begin m_per[c] = m_pend[c]; m_pend[c] = 0; end
          if (m_os[c]) m_dn[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    logic [NCH-1:0] et, ed, es;
    @(posedge clk_in);
    if (rst_n) model_edge();
    #1;
    for (int c = 0; c < NCH; c++) begin
      et[c] = m_tk[c]; ed[c] = m_dn[c]; es[c] = m_sq[c];
    end
    chk("model_tick", 32'(tick), 32'(et));
    chk("model_done", 32'(done), 32'(ed));
    chk("model_cfg_err", 32'(cfg_err), 32'(m_err));
`ifdef TICK_GEN_SQUARE_EN
    chk("model_sq", 32'(sq), 32'(es));
`else
    if (es != es) $display("unreachable");
`endif
  endtask

  task automatic cfg_write(input int ch, input int p, input bit os);
    cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_period = 8'(p); cfg_oneshot = os;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_tick(input int c, input int maxc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick[c] !== 1'b1 && n < maxc);
  endtask

  typedef struct {
    logic       v;
    logic [1:0] ch;
    logic [7:0] p;
    logic       os;
    logic       exp_err;
  } vec_t;

  vec_t vt[6];
  int   n;
  int   cnt_t;
  int   last;
  int   per_sq;
  logic prev;

  initial begin
    rst_n = 1'b0; en = '0; sync_in = 1'b0;
    cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_period = 8'd0; cfg_oneshot = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);

    // First ticks after reset release with default period.
    @(negedge clk_in);
    rst_n = 1'b1; en = 3'b111;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k == 9)  chk("first_tick_early", 32'(tick), 32'd0);
      if (k == 10) chk("first_tick", 32'(tick), 32'd7);
      if (k == 20) chk("second_tick", 32'(tick), 32'd7);
    end

    // Period change on a running channel takes effect after the current period.
    cfg_write(1, 4, 1'b0);
    wait_tick(1, 20, n); chk("ch1_old_period", n, 32'd10);
    wait_tick(1, 20, n); chk("ch1_new_period", n, 32'd4);
    wait_tick(1, 20, n); chk("ch1_new_period2", n, 32'd4);

    // One-shot on ch2.
    en[2] = 1'b0;
    cfg_write(2, 3, 1'b1);
    en[2] = 1'b1;
    wait_tick(2, 20, n);
    chk("oneshot_delay", n, 32'd3);
    chk("oneshot_done", 32'(done[2]), 32'd1);
    cnt_t = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      cnt_t += int'(tick[2]);
    end
    chk("oneshot_quiet", cnt_t, 32'd0);
    chk("oneshot_done_hold", 32'(done[2]), 32'd1);
    cfg_write(2, 3, 1'b1);
    chk("rewrite_clears_done", 32'(done[2]), 32'd0);
    wait_tick(2, 20, n);
    chk("oneshot_rewrite", n, 32'd3);

    // Config error vectors.
    vt[0] = '{1'b1, 2'd0, 8'd0,  1'b0, 1'b1};
    vt[1] = '{1'b1, 2'd3, 8'd5,  1'b0, 1'b1};
    vt[2] = '{1'b0, 2'd3, 8'd0,  1'b0, 1'b0};
    vt[3] = '{1'b1, 2'd2, 8'd0,  1'b1, 1'b1};
    vt[4] = '{1'b1, 2'd3, 8'd0,  1'b0, 1'b1};
    vt[5] = '{1'b1, 2'd0, 8'd10, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      cfg_valid = vt[i].v; cfg_ch = vt[i].ch; cfg_period = vt[i].p; cfg_oneshot = vt[i].os;
      step();
      cfg_valid = 1'b0;
      chk("cfg_err_vec", 32'(cfg_err), 32'(vt[i].exp_err));
      step();
      chk("cfg_err_pulse", 32'(cfg_err), 32'd0);
    end
    wait_tick(1, 20, n);
    wait_tick(1, 20, n); chk("ch1_period_kept", n, 32'd4);

    // Sync alignment and suppression of a coincident tick.
    cfg_write(0, 4, 1'b0);
    cfg_write(1, 4, 1'b0);
    cfg_write(2, 4, 1'b0);
    sync_in = 1'b1; step(); sync_in = 1'b0;
    chk("sync_no_tick", 32'(tick), 32'd0);
    wait_tick(0, 20, n);
    chk("sync_align_n", n, 32'd4);
    chk("sync_align", 32'(tick), 32'd7);
    repeat (3) step();
    sync_in = 1'b1; step(); sync_in = 1'b0;
    chk("sync_suppress", 32'(tick), 32'd0);
    wait_tick(0, 20, n);
    chk("sync_realign_n", n, 32'd4);
    chk("sync_realign", 32'(tick), 32'd7);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(9, 0) == 0) en = 3'($urandom_range(7, 0));
      sync_in     = ($urandom_range(39, 0) == 0);
      cfg_valid   = ($urandom_range(7, 0) == 0);
      cfg_ch      = 2'($urandom_range(3, 0));
      cfg_period  = 8'($urandom_range(12, 0));
      cfg_oneshot = 1'($urandom_range(1, 0));
      step();
    end
    sync_in = 1'b0; cfg_valid = 1'b0;

    // Mid-operation asynchronous reset.
    en = 3'b111;
    sync_in = 1'b1; step(); sync_in = 1'b0;
    en = 3'b010;
    cfg_write(0, 5, 1'b0);
    cfg_write(2, 2, 1'b1);
    en = 3'b111;
    repeat (15) step();
    chk("pre_rst_tick0", 32'(tick[0]), 32'd1);
    chk("pre_rst_done2", 32'(done[2]), 32'd1);
`ifdef TICK_GEN_SQUARE_EN
    chk("pre_rst_sq0", 32'(sq[0]), 32'd1);
`endif
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
`ifdef TICK_GEN_SQUARE_EN
    chk("arst_sq", 32'(sq), 32'd0);
`endif
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    step();
    chk("release_no_tick", 32'(tick), 32'd0);
    en[0] = 1'b0;
    cfg_write(0, 5, 1'b0);
    en[0] = 1'b1;
    wait_tick(0, 20, n); chk("p5_restart", n, 32'd5);
    wait_tick(0, 20, n); chk("p5_period", n, 32'd5);
`ifdef TICK_GEN_SQUARE_EN
    last = -1; per_sq = 0; prev = sq[0];
    for (int k = 0; k < 40; k++) begin
      step();
      if (sq[0] && !prev) begin
        if (last >= 0) per_sq = k - last;
        last = k;
      end
      prev = sq[0];
    end
    chk("sq_period", per_sq, 32'd10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tick_gen_multi.md
# tick_gen_multi

Parametrised multi-channel tick generator that replaces the fixed single-rate divider used to pace game logic (sprite motion, obstacle scroll, score update). Each of NUM_CH channels produces a one-cycle tick strobe at a runtime-programmable period and runs in periodic or one-shot mode. All channels share one clock. A global sync input restarts all channels phase-aligned.

## Interface
- NUM_CH, 4: number of independent channels (1..8).
- CNT_W, 22: counter/period width in bits.
- DEFAULT_DIV, 4000000: reset period of every channel, in clk_in cycles (25 Hz at 100 MHz).
- clk_in  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- en  in  NUM_CH  per-channel run enable (level).
- sync_in  in  1  one-cycle strobe; restarts all channels.
- cfg_valid  in  1  configuration write strobe.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel.
- cfg_period  in  CNT_W  new period P, in cycles.
- cfg_oneshot  in  1  1 = one-shot, 0 = periodic.
- cfg_err  out  1  one-cycle pulse: last write rejected.
- tick  out  NUM_CH  registered one-cycle strobes.
- done  out  NUM_CH  one-shot channel has fired and stopped.

## Operation
- Per channel: counter cnt, active period P_act, shadow P_sh, shadow-valid flag, mode bit, done bit.
- Reset: cnt=0, P_act=P_sh=DEFAULT_DIV, shadow-valid=0, mode=periodic, tick=0, done=0, cfg_err=0.
- Counting: when en=1 and done=0, cnt increments each cycle. When cnt==P_act-1, cnt wraps to 0 and tick is registered high for exactly one cycle.
- en=0: cnt holds its value; tick=0; pending shadow is applied immediately.
- P=1: tick is high every cycle while enabled.
- Config write, accepted every cycle (no backpressure):
  - cfg_period==0, or cfg_ch>=NUM_CH: write dropped; cfg_err=1 next cycle.
  - Otherwise: P_sh, shadow-valid and mode are written.
  - Channel enabled and running: P_sh moves to P_act at the next wrap.
  - Channel disabled or done: P_sh moves to P_act immediately.
  - Any accepted write clears done and zeroes cnt on the same edge.
- One-shot: on the first wrap, tick pulses, done sets, and cnt holds at 0. The channel stays stopped until an accepted cfg write or sync_in.
- sync_in, all channels on one edge: cnt=0; pending shadow applied; done cleared; tick=0 that cycle.
- Simultaneous sync_in and a cfg write to channel k: the write is accepted and the channel k result equals the write alone. Other channels are synced.
- A tick scheduled on the same edge as sync_in is suppressed.
- cnt never exceeds P_act-1. If P_act is shrunk below cnt by a shadow apply, this cannot occur, because shadows apply only at a wrap or with cnt zeroed.

## Timing
- All outputs are registered; no combinational input-to-output path.
- The first tick after rst_n release with en=1 is high in the cycle after the P-th rising edge. Ticks then repeat every P cycles exactly.
- cfg_err latency: 1 cycle after the cfg_valid edge.
- Mid-operation reset: every register returns to its reset value asynchronously. No tick is emitted on release.
- Tick period jitter: 0 cycles.

## Configuration
- TICK_GEN_SQUARE_EN defined: adds output port sq [NUM_CH], reset 0.
  - sq toggles on each tick of its channel, giving a 50% duty square wave with period 2P.
  - sync_in and accepted cfg writes force sq to 0.
- TICK_GEN_SQUARE_EN undefined: port sq and its logic are absent; all other behaviour is identical.

## Structure
- Package tick_gen_pkg holds:
  - default CNT_W and DEFAULT_DIV constants;
  - mode enum {MODE_PERIODIC, MODE_ONESHOT};
  - channel state struct (cnt, P_act, P_sh, shadow-valid, mode, done).
- Sub-module tick_gen_ch implements one channel; the top generates NUM_CH instances.
- The top decodes cfg_ch, produces cfg_err, and fans out sync_in.

## Test plan
- Reset with DEFAULT_DIV=10, en=1: first tick after the 10th edge, then every 10 cycles; done=0; no other tick bits set.
- Write ch1 P=4 while running at P=10: the current 10-cycle period completes, then ticks come every 4 cycles. Ch0 is unaffected.
- Write ch2 P=3 one-shot, en=1: exactly one tick 3 cycles later, then done=1 and no further ticks for 50 cycles. A rewrite clears done and restarts.
- cfg_period=0 or cfg_ch=NUM_CH: cfg_err pulses one cycle; channel periods are unchanged.
- sync_in mid-count on all channels: every cnt is 0 on the next cycle. Ticks with equal P are aligned afterwards; a tick coincident with sync_in is suppressed.
- rst_n asserted mid-count, with TICK_GEN_SQUARE_EN defined: tick, done and sq drop immediately. The P=5 channel restarts and sq has period 10 cycles.
